nand3_bist: RTL

Self-checking sequential tester for the 3-input NAND cell.
- On `start` it drives all eight input vectors onto the cell, waits a programmable settle time, samples the cell output and compares it with ~(a&b&c).
- It counts mismatches and reports pass/fail with a completion pulse.
- It sits beside the NAND3 instance as the hardware checking end of the stimulus/response interface, so the cell can be validated on silicon or FPGA without a simulator.

---
 rtl/nand3_bist_if.sv | 29 ++
 rtl/nand3_bist.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/nand3_bist_if.sv
// rtl/nand3_bist_if.sv - stimulus/response bundle between the BIST engine and the NAND3 cell
//
// Signals:
//   a, b, c  stimulus vector {a,b,c} driven by the tester, a = MSB
//   dut_out  response of the cell under test
// Modports:
//   master   tester side (drives a/b/c, observes dut_out)
//   slave    cell side (observes a/b/c, drives dut_out)

interface nand3_bist_if;
  logic a;
  logic b;
  logic c;
  logic dut_out;

  modport master (
    output a,
    output b,
    output c,
    input  dut_out
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    output dut_out
  );
endinterface

// File: rtl/nand3_bist.sv
// rtl/nand3_bist.sv - exhaustive self-checking sequential tester for a 3-input NAND cell
//
// Walks {a,b,c} through 000..111, holds each vector SETTLE_CYCLES cycles, then
// spends one CHECK cycle comparing the cell response against ~(a&b&c).
// Mismatches are counted (saturating) and the run ends with a one-cycle done pulse.
//
// Parameters:
//   SETTLE_CYCLES  cycles a vector is held before it is sampled (>= 1)
//   ERR_W          width of the saturating mismatch counter
// Ports:
//   clk               sole clock, rising edge
//   rst_n             asynchronous active-low reset
//   start_i           launches a run; only looked at in IDLE
//   cell_if           master side of the stimulus/response bundle
//   busy_o            high while vectors are being applied/checked
//   done_o            one-cycle pulse when a run completes
//   pass_o            run finished with zero mismatches; held until next start
//   err_cnt_o         saturating mismatch count; held until next start
//   first_fail_vld_o  (NAND3_BIST_ERRLOG_EN only) a mismatch has been logged
//   first_fail_vec_o  (NAND3_BIST_ERRLOG_EN only) vector of the first mismatch
//
// Optional feature macro: NAND3_BIST_ERRLOG_EN adds the first-failure log.

module nand3_bist #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  nand3_bist_if.master     cell_if,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o
`ifdef NAND3_BIST_ERRLOG_EN
  ,
  output logic             first_fail_vld_o,
  output logic [2:0]       first_fail_vec_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A single-cycle settle still needs a 1-bit counter to keep widths legal.
  localparam int unsigned     CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic [2:0]       abc_q, abc_d;
`ifdef NAND3_BIST_ERRLOG_EN
  logic             ffv_q, ffv_d;
  logic [2:0]       ffvec_q, ffvec_d;
`endif

  logic exp_out;
  logic mismatch;

  // Only vector 111 drives the NAND output low.
  assign exp_out  = (vec_q != 3'b111);
  assign mismatch = (cell_if.dut_out != exp_out);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    abc_d   = 3'b000;
`ifdef NAND3_BIST_ERRLOG_EN
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_APPLY;
          vec_d   = 3'b000;
          cnt_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
`ifdef NAND3_BIST_ERRLOG_EN
          ffv_d   = 1'b0;
          ffvec_d = 3'b000;
`endif
        end
      end

      S_APPLY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
`ifdef NAND3_BIST_ERRLOG_EN
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
`endif
        end
        if (vec_q == 3'b111) begin
          state_d = S_DONE;
          // Uses err_d so the final vector's result is included.
          pass_d  = (err_d == '0);
        end else begin
          state_d = S_APPLY;
          vec_d   = vec_q + 3'd1;
          cnt_d   = '0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Stimulus is registered from the next state so the cell sees clean edges.
    if ((state_d == S_APPLY) || (state_d == S_CHECK)) begin
      abc_d = vec_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 3'b000;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      abc_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      abc_q   <= abc_d;
    end
  end

`ifdef NAND3_BIST_ERRLOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ffv_q   <= 1'b0;
      ffvec_q <= 3'b000;
    end else begin
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign first_fail_vld_o = ffv_q;
  assign first_fail_vec_o = ffvec_q;
`endif

  assign cell_if.a = abc_q[2];
  assign cell_if.b = abc_q[1];
  assign cell_if.c = abc_q[0];

  assign busy_o    = (state_q == S_APPLY) || (state_q == S_CHECK);
  assign done_o    = (state_q == S_DONE);
  assign pass_o    = pass_q;
  assign err_cnt_o = err_q;

endmodule
